// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dm_access_ctrl_pkg;

  // Controller states: normal service, second half of a sub-word store, debug slot
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WR = 2'd1,
    ST_DBG    = 2'd2
  } state_t;

  // cpu_size encodings; 2'b11 is handled as a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DBG_WAIT_MAX_DEF = 8;
  localparam int AW_DEF           = 12;

  // Halves must sit on even bytes, words on word boundaries; bytes never fault
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte and half stores need a read-modify-write because DM is word-wide
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Lane steering: merges store data into a DM word and extracts/extends load data.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the results are used.
module dm_lane_unit
  import dm_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // One shifter serves all lanes: the offset picks the lane, the size picks the mask
  always_comb begin
    shamt     = 5'd0;
    mask      = 32'hFFFF_FFFF;
    lane8     = 8'd0;
    lane16    = 16'd0;
    merged    = wdata;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        shamt     = {byte_off, 3'b000};
        mask      = 32'h0000_00FF << shamt;
        merged    = (rdata & ~mask) | ({24'd0, wdata[7:0]} << shamt);
        lane8     = 8'(rdata >> shamt);
        load_data = {{24{sext & lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        shamt     = {byte_off[1], 4'b0000};
        mask      = 32'h0000_FFFF << shamt;
        merged    = (rdata & ~mask) | ({16'd0, wdata[15:0]} << shamt);
        lane16    = 16'(rdata >> shamt);
        load_data = {{16{sext & lane16[15]}}, lane16};
      end
      default: begin
        merged    = wdata;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Arbitrates the single-port DM between the Mem stage and the debug port, sequencing sub-word stores as RMW.
// Latency: loads and word stores 0 extra cycles; sub-word stores 2 cycles; debug access granted >=1 cycle after request.
// Backpressure: cpu_stall freezes the pipeline during RMW reads and debug slots; dbg_req is held until dbg_gnt.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int DBG_WAIT_MAX = DBG_WAIT_MAX_DEF,
  parameter int AW           = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic          cpu_sext,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic [31:0]   dbg_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  input  logic [31:0]   dm_rdata
);

  localparam int            CW      = $clog2(DBG_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DBG_WAIT_MAX);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   merge_q;
  logic [31:0]   dbg_rdata_q;
  logic          merge_load;
  logic          misaligned;
  logic          subword_st;
  logic [31:0]   lane_merged;
  logic [31:0]   lane_load;
  logic          unused_addr_bits;

  // Address bits outside the DM window carry no meaning here
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], dbg_addr[31:AW+2], dbg_addr[1:0]};

  assign misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
  assign subword_st = cpu_we & is_subword(cpu_size) & ~misaligned;

  dm_lane_unit u_lane (
    .size      (cpu_size),
    .sext      (cpu_sext),
    .byte_off  (cpu_addr[1:0]),
    .rdata     (dm_rdata),
    .wdata     (cpu_wdata),
    .merged    (lane_merged),
    .load_data (lane_load)
  );

  // State register; reset abandons any half-done RMW
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus DM, CPU and debug port drive; everything is held at 0 while in reset
  always_comb begin
    state_nxt  = state;
    cpu_rdata  = 32'd0;
    cpu_stall  = 1'b0;
    cpu_err    = 1'b0;
    dbg_gnt    = 1'b0;
    dm_addr    = '0;
    dm_wdata   = 32'd0;
    dm_we      = 1'b0;
    merge_load = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          dm_addr = cpu_addr[AW+1:2];
          if (cpu_req) begin
            if (misaligned) begin
              cpu_err = 1'b1;
            end else if (!cpu_we) begin
              cpu_rdata = lane_load;
            end else if (subword_st) begin
              cpu_stall  = 1'b1;
              merge_load = 1'b1;
            end else begin
              dm_we    = 1'b1;
              dm_wdata = cpu_wdata;
            end
          end
          // An RMW in progress is never pre-empted; debug waits for the next IDLE
          if (cpu_req && subword_st) begin
            state_nxt = ST_RMW_WR;
          end else if (dbg_req && (!cpu_req || starve_cnt == CNT_MAX)) begin
            state_nxt = ST_DBG;
          end
        end
        ST_RMW_WR: begin
          dm_addr   = cpu_addr[AW+1:2];
          dm_we     = 1'b1;
          dm_wdata  = merge_q;
          state_nxt = ST_IDLE;
        end
        ST_DBG: begin
          dm_addr   = dbg_addr[AW+1:2];
          dm_we     = dbg_we;
          dm_wdata  = dbg_wdata;
          dbg_gnt   = 1'b1;
          cpu_stall = cpu_req;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Merge capture, debug read capture and saturating starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      merge_q     <= 32'd0;
      dbg_rdata_q <= 32'd0;
      starve_cnt  <= '0;
    end else begin
      if (merge_load) begin
        merge_q <= lane_merged;
      end
      if (state == ST_DBG) begin
        dbg_rdata_q <= dm_rdata;
        starve_cnt  <= '0;
      end else if (dbg_req && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  assign dbg_rdata = reset ? 32'd0 : dbg_rdata_q;

endmodule
